mem_arbiter_nch: RTL and testbench

Byte-serial memory controller and arbiter that generalises the current two-client (ICache + LSB) memory controller to NUM_CH requesters.
- Serves 1/2/4-byte little-endian reads and writes over the 8-bit RAM bus.
- Arbitrates between requesters and stalls I/O writes on io_buffer_full.
- Supports per-channel read flush on misprediction clear.
- Sits between the cache/LSB clients and the top-level mem_* pins.

---
 rtl/mem_arbiter_nch.sv | 252 +++++++++++++++++++++++++
 tb/tb_mem_arbiter_nch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_nch.sv
// Byte-serial memory controller arbitrating NUM_CH requesters onto the 8-bit RAM bus.
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration instead of fixed priority.
module mem_arbiter_nch #(
    parameter int          NUM_CH       = 2,
    parameter int          ADDR_W       = 32,
    parameter logic [1:0]  IO_BASE_BITS = 2'b11
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_we,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*32-1:0]     ch_wdata,
    input  logic [NUM_CH*2-1:0]      ch_size,
    input  logic [NUM_CH-1:0]        ch_flush,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [31:0]              ch_rdata,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr,
    input  logic                     io_buffer_full
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_WRITE   = 3'd2,
        S_IO_WAIT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q;
    logic [NUM_CH-1:0]   done_q;
    logic [31:0]         rdata_q;
    logic [ADDR_W-1:0]   mem_a_q;
    logic [7:0]          dout_q;
    logic                wr_q;
    logic [IDX_W-1:0]    own_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         data_q;
    logic [2:0]          nb_q;
    logic [2:0]          k_q;

    logic [NUM_CH-1:0]   cand;
    logic                gnt_valid;
    logic [IDX_W-1:0]    gnt_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [31:0]         sel_wdata;
    logic [1:0]          sel_size;
    logic                sel_we;

    function automatic logic [2:0] size_to_bytes(input logic [1:0] s);
        case (s)
            2'd0:    size_to_bytes = 3'd1;
            2'd1:    size_to_bytes = 3'd2;
            default: size_to_bytes = 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [2:0] k);
        case (k[1:0])
            2'd0:    byte_sel = d[7:0];
            2'd1:    byte_sel = d[15:8];
            2'd2:    byte_sel = d[23:16];
            default: byte_sel = d[31:24];
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] d, input logic [2:0] k,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = d;
        case (k[1:0])
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        return a[17:16] == IO_BASE_BITS;
    endfunction

    // A flushing channel is never eligible, so flush wins over a same-cycle grant.
    assign cand = ch_req & ~ch_flush;

`ifdef MEM_ARB_RR_EN
    logic [IDX_W-1:0] rr_q;

    always_comb begin
        int c;
        c         = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            c = int'(rr_q) + j;
            if (c >= NUM_CH) c = c - NUM_CH;
            if (!gnt_valid && cand[c]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(c);
            end
        end
    end
`else
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        sel_addr  = ch_addr[ADDR_W-1:0];
        sel_wdata = ch_wdata[31:0];
        sel_size  = ch_size[1:0];
        sel_we    = ch_we[0];
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = ch_wdata[i*32 +: 32];
                sel_size  = ch_size[i*2 +: 2];
                sel_we    = ch_we[i];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            done_q  <= '0;
            rdata_q <= '0;
            mem_a_q <= '0;
            dout_q  <= '0;
            wr_q    <= 1'b0;
            own_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            nb_q    <= '0;
            k_q     <= '0;
`ifdef MEM_ARB_RR_EN
            rr_q    <= '0;
`endif
        end else if (!rdy_in) begin
            // Frozen; a byte already on the bus was written at this edge, so never repeat it.
            wr_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= '0;
                    if (gnt_valid) begin
                        own_q   <= gnt_idx;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        nb_q    <= size_to_bytes(sel_size);
                        k_q     <= '0;
                        data_q  <= '0;
`ifdef MEM_ARB_RR_EN
                        rr_q    <= (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
`endif
                        if (!sel_we) begin
                            mem_a_q <= sel_addr;
                            state_q <= S_READ;
                        end else if (is_io(sel_addr) && io_buffer_full) begin
                            state_q <= S_IO_WAIT;
                        end else begin
                            mem_a_q <= sel_addr;
                            dout_q  <= sel_wdata[7:0];
                            wr_q    <= 1'b1;
                            state_q <= S_WRITE;
                        end
                    end
                end

                // k_q counts READ edges: issue address k+1, capture byte k-1 (two-edge RAM latency).
                S_READ: begin
                    if (ch_flush[own_q]) begin
                        state_q <= S_IDLE;
                    end else begin
                        if (k_q + 3'd1 < nb_q)
                            mem_a_q <= addr_q + ADDR_W'(k_q + 3'd1);
                        if (k_q != 3'd0)
                            data_q <= put_byte(data_q, k_q - 3'd1, mem_din);
                        if (k_q == nb_q) begin
                            done_q[own_q] <= 1'b1;
                            rdata_q       <= put_byte(data_q, k_q - 3'd1, mem_din);
                            state_q       <= S_DONE;
                        end
                        k_q <= k_q + 3'd1;
                    end
                end

                // k_q is the byte currently on the bus.
                S_WRITE: begin
                    if (k_q + 3'd1 < nb_q) begin
                        if (is_io(addr_q) && io_buffer_full) begin
                            wr_q    <= 1'b0;
                            k_q     <= k_q + 3'd1;
                            state_q <= S_IO_WAIT;
                        end else begin
                            mem_a_q <= addr_q + ADDR_W'(k_q + 3'd1);
                            dout_q  <= byte_sel(wdata_q, k_q + 3'd1);
                            wr_q    <= 1'b1;
                            k_q     <= k_q + 3'd1;
                        end
                    end else begin
                        wr_q          <= 1'b0;
                        done_q[own_q] <= 1'b1;
                        state_q       <= S_DONE;
                    end
                end

                // k_q is the next byte still to be sent.
                S_IO_WAIT: begin
                    if (!io_buffer_full) begin
                        mem_a_q <= addr_q + ADDR_W'(k_q);
                        dout_q  <= byte_sel(wdata_q, k_q);
                        wr_q    <= 1'b1;
                        state_q <= S_WRITE;
                    end
                end

                S_DONE: begin
                    done_q  <= '0;
                    wr_q    <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ch_done  = done_q;
    assign ch_rdata = rdata_q;
    assign mem_a    = mem_a_q;
    assign mem_dout = dout_q;
    assign mem_wr   = wr_q;

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Directed bench for mem_arbiter_nch: RAM model, done/write scoreboards, latency and stall checks.
module tb_mem_arbiter_nch;

    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;

    logic                     clk = 1'b0;
    logic                     rst_in;
    logic                     rdy_in;
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_we;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*32-1:0]     ch_wdata;
    logic [NUM_CH*2-1:0]      ch_size;
    logic [NUM_CH-1:0]        ch_flush;
    logic [NUM_CH-1:0]        ch_done;
    logic [31:0]              ch_rdata;
    logic [7:0]               mem_din;
    logic [7:0]               mem_dout;
    logic [ADDR_W-1:0]        mem_a;
    logic                     mem_wr;
    logic                     io_buffer_full;

    logic [7:0] ram     [0:1023];
    int         wr_hits [0:1023];
    int         errors    = 0;
    int         checks    = 0;
    int         wr_cycles = 0;

    logic [40:0] exp_done_q[$];  // {is_read, one-hot done, rdata}
    logic [39:0] exp_wr_q[$];    // {addr, data}

    always #5 clk = ~clk;

    mem_arbiter_nch #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .IO_BASE_BITS(2'b11)) dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .ch_req         (ch_req),
        .ch_we          (ch_we),
        .ch_addr        (ch_addr),
        .ch_wdata       (ch_wdata),
        .ch_size        (ch_size),
        .ch_flush       (ch_flush),
        .ch_done        (ch_done),
        .ch_rdata       (ch_rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    // Synchronous RAM: read data appears one edge after the address.
    always @(posedge clk) begin
        if (mem_wr) begin
            ram[mem_a[9:0]] <= mem_dout;
            wr_hits[mem_a[9:0]]++;
        end
        mem_din <= ram[mem_a[9:0]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [39:0] ew;
        logic [40:0] ed;
        if (!rst_in) begin
            if (mem_wr) begin
                wr_cycles++;
                chk("wr_pending", 64'(exp_wr_q.size() != 0), 64'd1);
                if (exp_wr_q.size() != 0) begin
                    ew = exp_wr_q.pop_front();
                    chk("wr_addr", 64'(mem_a), 64'(ew[39:8]));
                    chk("wr_data", 64'(mem_dout), 64'(ew[7:0]));
                end
            end
            if (ch_done != '0) begin
                chk("done_pending", 64'(exp_done_q.size() != 0), 64'd1);
                if (exp_done_q.size() != 0) begin
                    ed = exp_done_q.pop_front();
                    chk("done_ch", 64'(ch_done), 64'(ed[39:32]));
                    if (ed[40]) chk("rdata", 64'(ch_rdata), 64'(ed[31:0]));
                end
            end
        end
    end

    task automatic set_req(input int ch, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size);
        ch_req[ch]                   = 1'b1;
        ch_we[ch]                    = we;
        ch_addr[ch*ADDR_W +: ADDR_W] = addr;
        ch_wdata[ch*32 +: 32]        = wdata;
        ch_size[ch*2 +: 2]           = size;
    endtask

    task automatic drop(input int ch);
        ch_req[ch] = 1'b0;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ch_done == '0 && n < max);
        chk("done_timeout", 64'(ch_done != '0), 64'd1);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_in = 1'b0;
    endtask

    initial begin
        int n;
        int w0;
        rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
        ch_req = '0; ch_we = '0; ch_addr = '0; ch_wdata = '0; ch_size = '0; ch_flush = '0;
        for (int i = 0; i < 1024; i++) begin
            ram[i]     = 8'h00;
            wr_hits[i] = 0;
        end
        ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
        ram[10'h206] = 8'h77;

        repeat (2) @(negedge clk);
        chk("rst_done",  64'(ch_done),  64'd0);
        chk("rst_rdata", 64'(ch_rdata), 64'd0);
        chk("rst_mem_a", 64'(mem_a),    64'd0);
        chk("rst_dout",  64'(mem_dout), 64'd0);
        chk("rst_wr",    64'(mem_wr),   64'd0);
        rst_in = 1'b0;
        @(negedge clk);

        // Two-byte read: done visible on the 4th cycle after the grant edge.
        exp_done_q.push_back({1'b1, 8'h01, 32'h0000_2211});
        set_req(0, 1'b0, 32'h100, 32'h0, 2'd1);
        wait_done(20, n);
        drop(0);
        chk("t1_latency", 64'(n), 64'd4);
        @(negedge clk);
        chk("t1_pulse_one_cycle", 64'(ch_done), 64'd0);

        // Two-byte write.
        w0 = wr_cycles;
        exp_wr_q.push_back({32'h204, 8'hEF});
        exp_wr_q.push_back({32'h205, 8'hBE});
        exp_done_q.push_back({1'b0, 8'h02, 32'h0});
        set_req(1, 1'b1, 32'h204, 32'hDEAD_BEEF, 2'd1);
        wait_done(20, n);
        drop(1);
        chk("t2_latency", 64'(n), 64'd3);
        chk("t2_wr_cycles", 64'(wr_cycles - w0), 64'd2);
        @(negedge clk);
        chk("t2_ram_205", 64'(ram[10'h205]), 64'hBE);
        chk("t2_ram_206", 64'(ram[10'h206]), 64'h77);

        // I/O write stalled by a full UART buffer.
        io_buffer_full = 1'b1;
        w0 = wr_cycles;
        exp_wr_q.push_back({32'h0003_0000, 8'h41});
        exp_done_q.push_back({1'b0, 8'h01, 32'h0});
        set_req(0, 1'b1, 32'h0003_0000, 32'h41, 2'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_wr", 64'(mem_wr), 64'd0);
        end
        io_buffer_full = 1'b0;
        wait_done(20, n);
        drop(0);
        chk("t3_latency", 64'(n), 64'd2);
        chk("t3_wr_cycles", 64'(wr_cycles - w0), 64'd1);
        @(negedge clk);

        // Contending reads; reset first so the round-robin pointer starts at 0.
        do_reset();
        @(negedge clk);
`ifdef MEM_ARB_RR_EN
        exp_done_q.push_back({1'b1, 8'h01, 32'h11});
        exp_done_q.push_back({1'b1, 8'h02, 32'h22});
        exp_done_q.push_back({1'b1, 8'h01, 32'h11});
`else
        exp_done_q.push_back({1'b1, 8'h01, 32'h11});
        exp_done_q.push_back({1'b1, 8'h01, 32'h11});
        exp_done_q.push_back({1'b1, 8'h01, 32'h11});
`endif
        set_req(0, 1'b0, 32'h100, 32'h0, 2'd0);
        set_req(1, 1'b0, 32'h101, 32'h0, 2'd0);
        for (int t = 0; t < 3; t++) begin
            wait_done(20, n);
            chk("t4_latency", 64'(n), (t == 0) ? 64'd3 : 64'd4);
        end
        drop(0);
        drop(1);
        @(negedge clk);

        // Flush an active read one cycle after its grant.
        exp_done_q.push_back({1'b1, 8'h02, 32'h22});
        set_req(0, 1'b0, 32'h100, 32'h0, 2'd1);
        @(negedge clk);
        ch_flush[0] = 1'b1;
        set_req(1, 1'b0, 32'h101, 32'h0, 2'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                ch_flush[0] = 1'b0;
                drop(0);
            end
            if (n == 3) begin
                chk("t5_no_done", 64'(ch_done), 64'd0);
                chk("t5_rdata_kept", 64'(ch_rdata), 64'h11);
            end
        end while (ch_done == '0 && n < 20);
        drop(1);
        chk("t5_latency", 64'(n), 64'd4);
        @(negedge clk);

        // Four-byte write paused by rdy_in for three cycles.
        w0 = wr_cycles;
        exp_wr_q.push_back({32'h300, 8'hBE});
        exp_wr_q.push_back({32'h301, 8'hBA});
        exp_wr_q.push_back({32'h302, 8'hFE});
        exp_wr_q.push_back({32'h303, 8'hCA});
        exp_done_q.push_back({1'b0, 8'h01, 32'h0});
        set_req(0, 1'b1, 32'h300, 32'hCAFE_BABE, 2'd2);
        repeat (2) @(negedge clk);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_paused_wr", 64'(mem_wr), 64'd0);
        end
        rdy_in = 1'b1;
        wait_done(20, n);
        drop(0);
        chk("t6_latency", 64'(n), 64'd3);
        chk("t6_wr_cycles", 64'(wr_cycles - w0), 64'd4);
        @(negedge clk);
        chk("t6_ram", 64'({ram[10'h303], ram[10'h302], ram[10'h301], ram[10'h300]}), 64'hCAFE_BABE);
        for (int a = 10'h300; a <= 10'h303; a++)
            chk("t6_write_once", 64'(wr_hits[a]), 64'd1);

        repeat (3) @(negedge clk);
        chk("exp_done_drained", 64'(exp_done_q.size()), 64'd0);
        chk("exp_wr_drained", 64'(exp_wr_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
